// File: rtl/pu_mac.sv
// pu_mac: signed multi-lane multiply-accumulate unit fed by the matrix
// controller, with a registered valid/ready result port for writeback.
module pu_mac #(
    parameter int MAC_NUM = 1,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [MAC_NUM*DATA_W-1:0] din1_i,
    input  logic [MAC_NUM*DATA_W-1:0] din2_i,
    input  logic                      pu_en_i,
    input  logic                      pu_valid_i,
    output logic [ACC_W-1:0]          dout_o,
    output logic                      dout_valid_o,
    input  logic                      dout_ready_i,
    output logic                      busy_o,
    output logic                      overrun_o
);

    localparam int PW = 2 * DATA_W;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    logic signed [PW-1:0] lane_p [MAC_NUM];
    logic [ACC_W-1:0]     prod;
    logic [ACC_W-1:0]     sum;
    logic                 last_beat;

    // Sum of per-lane signed products, each sign-extended to ACC_W.
    always_comb begin
        prod = '0;
        for (int k = 0; k < MAC_NUM; k++) begin
            lane_p[k] = $signed(din1_i[k*DATA_W +: DATA_W])
                      * $signed(din2_i[k*DATA_W +: DATA_W]);
            prod = prod + {{(ACC_W-PW){lane_p[k][PW-1]}}, lane_p[k]};
        end
    end

    // Running sum including this beat; an IDLE beat starts fresh from P.
    always_comb begin
        last_beat = pu_en_i & pu_valid_i;
        sum       = (state_q == ACC) ? acc_q + prod : prod;
    end

    // State register plus datapath flops; reset discards any partial sum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next state: an enabled beat enters ACC, a final beat returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pu_en_i && !pu_valid_i) state_d = ACC;
            ACC:  if (last_beat)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accumulator and result register with valid/ready and sticky overrun.
    always_comb begin
        acc_d        = acc_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        if (pu_en_i) begin
            acc_d = pu_valid_i ? '0 : sum;
        end
        if (last_beat) begin
            dout_d       = sum;
            dout_valid_d = 1'b1;
            if (dout_valid_q && !dout_ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready_i) begin
            dout_valid_d = 1'b0;
        end
    end

    // Outputs are driven straight from state and registers.
    always_comb begin
        busy_o       = (state_q == ACC);
        dout_o       = dout_q;
        dout_valid_o = dout_valid_q;
        overrun_o    = overrun_q;
    end

endmodule

// File: tb/tb_pu_mac.sv
// tb_pu_mac: directed tests of pu_mac with hand-computed dot products,
// covering a single-lane and a two-lane instance.
module tb_pu_mac;

    logic        clk;
    logic        rst;
    logic [7:0]  d1, d2;
    logic        en, vld, rdy;
    logic [23:0] dout;
    logic        dvld, busy, ovr;

    logic [15:0] e1, e2;
    logic        en2, vld2;
    logic [23:0] dout2;
    logic        dvld2, busy2, ovr2;

    int checks = 0;
    int errors = 0;

    pu_mac #(.MAC_NUM(1), .DATA_W(8), .ACC_W(24)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .din1_i      (d1),
        .din2_i      (d2),
        .pu_en_i     (en),
        .pu_valid_i  (vld),
        .dout_o      (dout),
        .dout_valid_o(dvld),
        .dout_ready_i(rdy),
        .busy_o      (busy),
        .overrun_o   (ovr)
    );

    pu_mac #(.MAC_NUM(2), .DATA_W(8), .ACC_W(24)) u_dut2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .din1_i      (e1),
        .din2_i      (e2),
        .pu_en_i     (en2),
        .pu_valid_i  (vld2),
        .dout_o      (dout2),
        .dout_valid_o(dvld2),
        .dout_ready_i(1'b1),
        .busy_o      (busy2),
        .overrun_o   (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat, then step past the sampling edge.
    task automatic beat(input logic e, input logic v,
                        input logic [7:0] a, input logic [7:0] b);
        en  = e;
        vld = v;
        d1  = a;
        d2  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    // Vector 1..8 x 1..8 (sum 204).
    task automatic vec204;
        for (int i = 1; i <= 8; i++) begin
            beat(1'b1, i == 8, 8'(i), 8'(i));
        end
    endtask

    // Vector of eight 1x1 beats (sum 8).
    task automatic vec8;
        for (int i = 1; i <= 8; i++) beat(1'b1, i == 8, 8'd1, 8'd1);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        en = 0; vld = 0; d1 = 0; d2 = 0;
        en2 = 0; vld2 = 0; e1 = 0; e2 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dvld", 32'(dvld), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        rst = 1'b0;

        // Basic 8-beat vector with ready held high.
        for (int i = 1; i <= 7; i++) begin
            beat(1'b1, 1'b0, 8'(i), 8'(i));
            chk("t1_busy", 32'(busy), 32'h1);
            chk("t1_novld", 32'(dvld), 32'h0);
        end
        beat(1'b1, 1'b1, 8'd8, 8'd8);
        chk("t1_dout", 32'(dout), 32'd204);
        chk("t1_dvld", 32'(dvld), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);
        idle(1);
        chk("t1_dvld_drop", 32'(dvld), 32'h0);
        chk("t1_dout_hold", 32'(dout), 32'd204);

        // Signed operands.
        for (int i = 1; i <= 8; i++) beat(1'b1, i == 8, 8'hFF, 8'h02);
        chk("neg16", 32'(dout), 32'hFFFFF0);
        for (int i = 1; i <= 8; i++) beat(1'b1, i == 8, 8'h80, 8'h80);
        chk("min_sq", 32'(dout), 32'h020000);

        // Single-beat vector from IDLE: 3 * -4.
        beat(1'b1, 1'b1, 8'd3, 8'hFC);
        chk("single_dout", 32'(dout), 32'hFFFFF4);
        chk("single_busy", 32'(busy), 32'h0);
        chk("single_dvld", 32'(dvld), 32'h1);
        idle(1);

        // Gaps mid-vector, then a back-to-back vector.
        for (int i = 1; i <= 4; i++) beat(1'b1, 1'b0, 8'(i), 8'(i));
        idle(3);
        chk("gap_busy", 32'(busy), 32'h1);
        chk("gap_novld", 32'(dvld), 32'h0);
        for (int i = 5; i <= 8; i++) beat(1'b1, i == 8, 8'(i), 8'(i));
        chk("gap_dout", 32'(dout), 32'd204);
        vec8();
        chk("b2b_dout", 32'(dout), 32'd8);
        chk("b2b_dvld", 32'(dvld), 32'h1);
        chk("b2b_ovr", 32'(ovr), 32'h0);
        idle(1);

        // Backpressure: B overwrites unaccepted A.
        rdy = 1'b0;
        vec204();
        chk("bp_a_dout", 32'(dout), 32'd204);
        for (int i = 1; i <= 7; i++) beat(1'b1, 1'b0, 8'd1, 8'd1);
        chk("bp_a_stable", 32'(dout), 32'd204);
        chk("bp_a_dvld", 32'(dvld), 32'h1);
        beat(1'b1, 1'b1, 8'd1, 8'd1);
        chk("bp_b_dout", 32'(dout), 32'd8);
        chk("bp_ovr", 32'(ovr), 32'h1);
        rdy = 1'b1;
        idle(1);
        chk("bp_xfer_dvld", 32'(dvld), 32'h0);
        chk("bp_hold_dout", 32'(dout), 32'd8);
        idle(2);
        chk("bp_ovr_sticky", 32'(ovr), 32'h1);

        // Reset clears overrun; ready on B's load cycle avoids overrun.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst2_ovr", 32'(ovr), 32'h0);
        rdy = 1'b0;
        vec204();
        for (int i = 1; i <= 7; i++) beat(1'b1, 1'b0, 8'd1, 8'd1);
        rdy = 1'b1;
        beat(1'b1, 1'b1, 8'd1, 8'd1);
        chk("rdy_b_dout", 32'(dout), 32'd8);
        chk("rdy_b_dvld", 32'(dvld), 32'h1);
        chk("rdy_b_ovr", 32'(ovr), 32'h0);

        // Reset mid-accumulation with a pending result.
        rdy = 1'b0;
        for (int i = 1; i <= 5; i++) beat(1'b1, 1'b0, 8'(i), 8'(i));
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        beat(1'b1, 1'b0, 8'd6, 8'd6);
        rst = 1'b0;
        chk("mid_rst_dout", 32'(dout), 32'h0);
        chk("mid_rst_dvld", 32'(dvld), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ovr", 32'(ovr), 32'h0);
        rdy = 1'b1;
        vec204();
        chk("post_rst_dout", 32'(dout), 32'd204);
        idle(1);

        // pu_valid_i without pu_en_i inside ACC is ignored.
        for (int i = 1; i <= 3; i++) beat(1'b1, 1'b0, 8'(i), 8'(i));
        beat(1'b0, 1'b1, 8'd50, 8'd50);
        chk("ign_dvld", 32'(dvld), 32'h0);
        chk("ign_busy", 32'(busy), 32'h1);
        for (int i = 4; i <= 8; i++) beat(1'b1, i == 8, 8'(i), 8'(i));
        chk("ign_dout", 32'(dout), 32'd204);
        idle(1);

        // Two-lane instance: lanes (1,2) x (1,2), 4 beats.
        for (int i = 1; i <= 4; i++) begin
            en2  = 1'b1;
            vld2 = (i == 4);
            e1   = 16'h0201;
            e2   = 16'h0201;
            @(posedge clk); #1;
        end
        en2 = 1'b0; vld2 = 1'b0;
        chk("lane2_dout", 32'(dout2), 32'd20);
        chk("lane2_dvld", 32'(dvld2), 32'h1);
        chk("lane2_ovr", 32'(ovr2), 32'h0);
        chk("lane2_busy", 32'(busy2), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_mac.md
Name: pu_mac

Overview:
- Processing unit directly downstream of the matrix-controller FSM and its two operand BRAMs.
- Consumes the controller's pu_en/pu_valid strobes and the BRAM read data, and performs a signed multiply-accumulate over MAC_NUM lanes per cycle.
- Registers the dot-product result and presents it on a valid/ready output port for the writeback stage.

Parameters:
- MAC_NUM, 1: parallel multiplier lanes per cycle; must match the controller.
- DATA_W, 8: signed operand width per lane.
- ACC_W, 24: signed accumulator and result width; must be ≥ 2*DATA_W + clog2(ELEMENTS).

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- din1_i  input  MAC_NUM*DATA_W  operand A lanes; lane k is bits [k*DATA_W +: DATA_W], two's complement.
- din2_i  input  MAC_NUM*DATA_W  operand B lanes, same packing.
- pu_en_i  input  1  operands on din1_i/din2_i are valid this cycle; accumulate them.
- pu_valid_i  input  1  marks the last accumulate of a vector; qualified by pu_en_i.
- dout_o  output  ACC_W  signed dot-product result.
- dout_valid_o  output  1  dout_o holds an unconsumed result.
- dout_ready_i  input  1  downstream accepts dout_o when dout_valid_o=1.
- busy_o  output  1  accumulation in progress (state ACC).
- overrun_o  output  1  sticky: a result was overwritten before acceptance.

Behaviour:
- Reset (rst_i=1 at clock edge): acc=0, dout_o=0, dout_valid_o=0, busy_o=0, overrun_o=0, state=IDLE. Reset overrides every other input, including mid-accumulation; a partial sum is discarded.
- Per-cycle product: P = sum over k of signed(din1 lane k) × signed(din2 lane k), sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W with no saturation.
- State machine has two states, IDLE and ACC; dout_valid_o is tracked separately.
- IDLE:
  - pu_en_i=1 and pu_valid_i=0: acc <= P, go to ACC.
  - pu_en_i=1 and pu_valid_i=1: single-beat vector; result = P; acc <= 0; stay in IDLE.
  - pu_en_i=0: hold.
- ACC:
  - pu_en_i=1 and pu_valid_i=0: acc <= acc + P.
  - pu_en_i=1 and pu_valid_i=1: result = acc + P; acc <= 0; go to IDLE.
  - pu_en_i=0: hold acc, stay in ACC (gaps allowed).
- pu_valid_i with pu_en_i=0 is ignored in both states.
- busy_o = (state == ACC).
- Result latency: dout_o and dout_valid_o update on the same edge that samples the final pu_en_i/pu_valid_i beat, so they are visible the next cycle (1-cycle latency).
- Output handshake:
  - A result is transferred on any cycle with dout_valid_o=1 and dout_ready_i=1.
  - dout_o is stable while dout_valid_o=1 and not yet transferred.
  - After a transfer with no new result arriving, dout_valid_o <= 0 and dout_o holds its last value.
- Simultaneous events:
  - New result with dout_valid_o=1 and dout_ready_i=1: the old result transfers, the new one loads, dout_valid_o stays 1, no overrun.
  - New result with dout_valid_o=1 and dout_ready_i=0: the new result overwrites dout_o, dout_valid_o stays 1, overrun_o <= 1. overrun_o clears only on reset.
- Back-to-back vectors: the first pu_en_i after a final beat starts a new sum from P, with no bubble required.

Test Plan:
- MAC_NUM=1: 8 beats, din1=1..8, din2=1..8, pu_valid_i on beat 8, dout_ready_i=1 → dout_o=204 (0x0000CC) with dout_valid_o=1 for exactly one cycle, 1 cycle after beat 8; busy_o high beats 1–8.
- Signed operands: 8 beats of din1=0xFF (−1), din2=0x02 → dout_o=0xFFFFF0 (−16). Then 8 beats of din1=0x80, din2=0x80 → dout_o=0x020000 (131072).
- Gaps and back-to-back: vector 1..8 with pu_en_i low for 3 cycles after beat 4 → 204. Immediately follow with 8 beats of 1×1 → 8. Verify no carry-over between vectors.
- Backpressure: dout_ready_i=0; complete vector A (=204), then vector B (=8) → dout_o=8, overrun_o=1. Raise ready → one transfer, dout_valid_o falls. Repeat with ready=1 on B's load cycle → overrun_o stays 0.
- Reset mid-operation: assert rst_i after beat 5 → all outputs 0 next cycle. A fresh 8-beat vector then yields 204 with no residue.
- pu_valid_i=1 with pu_en_i=0 in ACC → ignored, no output. MAC_NUM=2 config, 4 beats of lanes (1,2)×(1,2) → dout_o=20.
